// File: rtl/cmp_pkg.sv
// Shared types and helpers for the bit-serial magnitude comparator.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Ceiling log2, usable in parameter expressions.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/comp_bit_cell.sv
// One-bit magnitude compare cell: less, equal, greater for a single bit pair.
module comp_bit_cell (
  input  logic a,
  input  logic b,
  output logic l,
  output logic e,
  output logic g
);

  assign l = ~a & b;
  assign e = a ~^ b;
  assign g = a & ~b;

endmodule

// File: rtl/serial_mag_comparator.sv
// Bit-serial unsigned magnitude comparator, MSB first, driving one comp_bit_cell.
module serial_mag_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int EARLY_EXIT = 1,
  localparam int CW        = clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic             lt,
  output logic             eq,
  output logic             gt,
  output logic [CW-1:0]    cycles
);

  localparam int CNTW = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);

  state_e           state_r;
  logic [WIDTH-1:0] sa_r;
  logic [WIDTH-1:0] sb_r;
  logic [CNTW-1:0]  cnt_r;
  logic             sticky_r;
  logic             sticky_lt_r;
  logic             sticky_gt_r;
  logic             cell_l_s;
  logic             cell_e_s;
  logic             cell_g_s;

  comp_bit_cell u_cell (
    .a (sa_r[WIDTH-1]),
    .b (sb_r[WIDTH-1]),
    .l (cell_l_s),
    .e (cell_e_s),
    .g (cell_g_s)
  );

  // Control FSM, operand shifters, sticky first-difference flag and result flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      sa_r        <= {WIDTH{1'b0}};
      sb_r        <= {WIDTH{1'b0}};
      cnt_r       <= {CNTW{1'b0}};
      sticky_r    <= 1'b0;
      sticky_lt_r <= 1'b0;
      sticky_gt_r <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      lt          <= 1'b0;
      eq          <= 1'b0;
      gt          <= 1'b0;
      cycles      <= {CW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sa_r        <= a_in;
            sb_r        <= b_in;
            cnt_r       <= CNTW'(WIDTH - 1);
            cycles      <= {CW{1'b0}};
            sticky_r    <= 1'b0;
            sticky_lt_r <= 1'b0;
            sticky_gt_r <= 1'b0;
            lt          <= 1'b0;
            eq          <= 1'b0;
            gt          <= 1'b0;
            busy        <= 1'b1;
            state_r     <= RUN;
          end
        end
        RUN: begin
          cycles <= cycles + CW'(1);
          if ((EARLY_EXIT != 0) && !cell_e_s) begin
            lt      <= cell_l_s;
            gt      <= cell_g_s;
            eq      <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            state_r <= DONE;
          end else begin
            if (!sticky_r && !cell_e_s) begin
              sticky_r    <= 1'b1;
              sticky_lt_r <= cell_l_s;
              sticky_gt_r <= cell_g_s;
            end
            sa_r <= sa_r << 1;
            sb_r <= sb_r << 1;
            if (cnt_r == {CNTW{1'b0}}) begin
              // The last bit still counts if no earlier bit differed.
              if (sticky_r) begin
                lt <= sticky_lt_r;
                gt <= sticky_gt_r;
                eq <= 1'b0;
              end else begin
                lt <= cell_l_s;
                gt <= cell_g_s;
                eq <= cell_e_s;
              end
              busy    <= 1'b0;
              done    <= 1'b1;
              state_r <= DONE;
            end else begin
              cnt_r <= cnt_r - CNTW'(1);
            end
          end
        end
        DONE: begin
          done    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Bench: two comparators (EARLY_EXIT=0 and 1) checked every cycle against a behavioural model.
module tb_serial_mag_comparator;

  localparam int W  = 8;
  localparam int CW = 4;

  logic         clk;
  logic         rst;
  logic [1:0]   start_v;
  logic [W-1:0] a_v [2];
  logic [W-1:0] b_v [2];
  logic [1:0]   busy_v, done_v, lt_v, eq_v, gt_v;
  logic [CW-1:0] cyc_v [2];

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model state per instance (index 0: EARLY_EXIT=0, index 1: EARLY_EXIT=1).
  logic [1:0]    m_busy = '0, m_done = '0, m_lt = '0, m_eq = '0, m_gt = '0;
  logic [1:0]    p_lt = '0, p_eq = '0, p_gt = '0;
  logic [CW-1:0] m_cyc [2] = '{4'd0, 4'd0};
  int            m_left [2] = '{0, 0};

  serial_mag_comparator #(.WIDTH(W), .EARLY_EXIT(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .a_in(a_v[0]), .b_in(b_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .lt(lt_v[0]), .eq(eq_v[0]), .gt(gt_v[0]),
    .cycles(cyc_v[0])
  );

  serial_mag_comparator #(.WIDTH(W), .EARLY_EXIT(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .a_in(a_v[1]), .b_in(b_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .lt(lt_v[1]), .eq(eq_v[1]), .gt(gt_v[1]),
    .cycles(cyc_v[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int k, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s dut%0d got=%0h expected=%0h at %0t", nm, k, got, exp, $time);
    end
  endtask

  // RUN cycles needed: with early exit, stop at the first differing bit from the MSB.
  function automatic int exp_cycles(input logic [W-1:0] a, input logic [W-1:0] b, input bit ee);
    if (!ee) return W;
    for (int i = W - 1; i >= 0; i--) begin
      if (a[i] != b[i]) return W - i;
    end
    return W;
  endfunction

  // Behavioural reference: timeline of start -> RUN(n cycles) -> DONE -> IDLE.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_busy[k] = 1'b0; m_done[k] = 1'b0;
        m_lt[k] = 1'b0; m_eq[k] = 1'b0; m_gt[k] = 1'b0;
        m_cyc[k] = 4'd0; m_left[k] = 0;
      end else if (m_done[k]) begin
        m_done[k] = 1'b0;
      end else if (m_busy[k]) begin
        m_cyc[k]  = m_cyc[k] + 4'd1;
        m_left[k] = m_left[k] - 1;
        if (m_left[k] == 0) begin
          m_busy[k] = 1'b0; m_done[k] = 1'b1;
          m_lt[k] = p_lt[k]; m_eq[k] = p_eq[k]; m_gt[k] = p_gt[k];
        end
      end else if (start_v[k]) begin
        m_busy[k] = 1'b1;
        m_lt[k] = 1'b0; m_eq[k] = 1'b0; m_gt[k] = 1'b0;
        m_cyc[k] = 4'd0;
        m_left[k] = exp_cycles(a_v[k], b_v[k], k == 1);
        p_lt[k] = (a_v[k] < b_v[k]);
        p_eq[k] = (a_v[k] == b_v[k]);
        p_gt[k] = (a_v[k] > b_v[k]);
      end
    end
  end

  // Per-cycle comparison of both DUTs against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        chk("busy", k, busy_v[k], m_busy[k]);
        chk("done", k, done_v[k], m_done[k]);
        chk("lt", k, lt_v[k], m_lt[k]);
        chk("eq", k, eq_v[k], m_eq[k]);
        chk("gt", k, gt_v[k], m_gt[k]);
        chk("cycles", k, cyc_v[k], m_cyc[k]);
        if (done_v[k]) chk("onehot", k, $countones({lt_v[k], eq_v[k], gt_v[k]}), 1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_one(input int k, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int e_lat, input int e_lt, input int e_eq, input int e_gt,
                         input int e_cyc, input string nm);
    int lat;
    @(negedge clk);
    a_v[k] = a; b_v[k] = b; start_v[k] = 1'b1;
    lat = 0;
    do begin
      tick();
      lat++;
      start_v[k] = 1'b0;
      a_v[k] = ~a; b_v[k] = a;
    end while (!done_v[k] && lat < 40);
    chk({nm, "_latency"}, k, lat, e_lat);
    chk({nm, "_lt"}, k, lt_v[k], e_lt);
    chk({nm, "_eq"}, k, eq_v[k], e_eq);
    chk({nm, "_gt"}, k, gt_v[k], e_gt);
    chk({nm, "_cycles"}, k, cyc_v[k], e_cyc);
    tick();
  endtask

  task automatic rand_driver(input int k);
    for (int it = 0; it < 40; it++) begin
      @(negedge clk);
      a_v[k] = W'($urandom);
      case ($urandom_range(0, 3))
        0:       b_v[k] = a_v[k];
        1:       b_v[k] = a_v[k] ^ (8'h01 << $urandom_range(0, 7));
        default: b_v[k] = W'($urandom);
      endcase
      start_v[k] = 1'b1;
      repeat ($urandom_range(1, 12)) @(negedge clk);
      start_v[k] = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  initial begin
    int n;
    rst = 1'b1;
    start_v = 2'b00;
    a_v[0] = '0; b_v[0] = '0; a_v[1] = '0; b_v[1] = '0;

    chk("model_cyc_80_7f", 1, exp_cycles(8'h80, 8'h7F, 1'b1), 1);
    chk("model_cyc_12_13", 1, exp_cycles(8'h12, 8'h13, 1'b1), 8);
    chk("model_cyc_03_05", 1, exp_cycles(8'h03, 8'h05, 1'b1), 6);
    chk("model_cyc_no_ee", 0, exp_cycles(8'h80, 8'h7F, 1'b0), 8);

    repeat (2) tick();
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk("rst_busy", k, busy_v[k], 0);
      chk("rst_done", k, done_v[k], 0);
      chk("rst_res", k, {lt_v[k], eq_v[k], gt_v[k]}, 0);
      chk("rst_cycles", k, cyc_v[k], 0);
    end
    chk_en = 1'b1;

    run_one(1, 8'hA5, 8'hA5, 9, 0, 1, 0, 8, "ee_equal");
    run_one(1, 8'h80, 8'h7F, 2, 0, 0, 1, 1, "ee_msb_gt");
    run_one(1, 8'h12, 8'h13, 9, 1, 0, 0, 8, "ee_lsb_lt");
    run_one(0, 8'h40, 8'h3F, 9, 0, 0, 1, 8, "full_sticky_gt");
    run_one(0, 8'h12, 8'h13, 9, 1, 0, 0, 8, "full_lsb_lt");
    run_one(0, 8'hA5, 8'hA5, 9, 0, 1, 0, 8, "full_equal");

    // start held high across a whole compare; only IDLE starts are taken
    @(negedge clk);
    a_v[1] = 8'd3; b_v[1] = 8'd5; start_v[1] = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!done_v[1] && n < 40);
    chk("hold_first_latency", 1, n, 7);
    chk("hold_first_lt", 1, lt_v[1], 1);
    a_v[1] = 8'd9; b_v[1] = 8'd1;
    tick();
    chk("hold_idle_gap_busy", 1, busy_v[1], 0);
    tick();
    chk("hold_reaccept_busy", 1, busy_v[1], 1);
    n = 0;
    do begin tick(); n++; end while (!done_v[1] && n < 40);
    start_v[1] = 1'b0;
    chk("hold_second_latency", 1, n, 5);
    chk("hold_second_gt", 1, gt_v[1], 1);
    chk("hold_second_cycles", 1, cyc_v[1], 5);
    repeat (2) tick();

    // reset in the third RUN cycle aborts without a done pulse
    @(negedge clk);
    a_v[1] = 8'h12; b_v[1] = 8'h13; start_v[1] = 1'b1;
    tick();
    start_v[1] = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", 1, busy_v[1], 0);
    chk("abort_res", 1, {lt_v[1], eq_v[1], gt_v[1]}, 0);
    chk("abort_cycles", 1, cyc_v[1], 0);
    n = 0;
    repeat (10) begin tick(); if (done_v[1]) n++; end
    chk("abort_no_done", 1, n, 0);
    run_one(1, 8'h00, 8'h00, 9, 0, 1, 0, 8, "after_abort_zero");

    fork
      rand_driver(0);
      rand_driver(1);
    join
    repeat (20) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
